adc_receiver: RTL



---
 rtl/adc_receiver_pkg.sv | 20 ++
 rtl/adc_receiver_if.sv | 19 +
 rtl/sync_2ff.sv | 23 ++
 rtl/adc_receiver.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/adc_receiver_pkg.sv
// Shared types and constants for the left-justified serial audio receiver.
//   state_t        : receiver state (HUNT, LEFT, RIGHT)
//   cnt_width()    : width of the per-channel bit counter for a given sample width;
//                    wide enough to count up to 2*WIDTH without wrapping
//   MIN_CLK_RATIO  : minimum clk/bclk frequency ratio the oversampler relies on
package adc_receiver_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  localparam int MIN_CLK_RATIO = 4;

  function automatic int cnt_width(input int width);
    return $clog2(2 * width) + 1;
  endfunction

endpackage

// File: rtl/adc_receiver_if.sv
// Parallel sample stream presented by the receiver to the DSP input stage.
//   left_data/right_data : captured sample pair
//   valid/ready          : pair handshake (transfer when both high)
//   overrun              : pulse when a completed pair was dropped
//   frame_err            : pulse when a channel carried the wrong bit count
// master = receiver side, slave = consumer side.
interface adc_receiver_if #(
  parameter int WIDTH = 24
);
  logic [WIDTH-1:0] left_data;
  logic [WIDTH-1:0] right_data;
  logic             valid;
  logic             ready;
  logic             overrun;
  logic             frame_err;

  modport master (output left_data, right_data, valid, overrun, frame_err, input ready);
  modport slave  (input left_data, right_data, valid, overrun, frame_err, output ready);
endinterface

// File: rtl/sync_2ff.sv
// Multi-flop synchroniser for a single asynchronous input.
//   clk, rst_n : destination clock, async active-low reset (chain clears to 0)
//   d          : asynchronous input
//   q          : synchronised output, STAGES clocks of latency
module sync_2ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/adc_receiver.sv
// Left-justified serial audio receiver. Oversamples bclk/lrclk/sd on clk
// (clk >= 4x bclk), deserialises each left/right frame MSB first and presents
// the pair on a valid/ready stream.
//   clk, rst_n        : system clock, async active-low reset
//   enable            : receiver enable; low forces re-lock and drops partial frames
//   bclk, lrclk, sd   : asynchronous serial pins (lrclk high = left channel)
//   bus (master)      : left_data, right_data, valid, ready, overrun, frame_err
// Optional feature: define ADC_RECEIVER_FRAME_CHECK_EN to build the per-channel
// bit-count check that drives frame_err; otherwise frame_err is tied 0.
module adc_receiver
  import adc_receiver_pkg::*;
#(
  parameter int WIDTH       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          bclk,
  input  logic          lrclk,
  input  logic          sd,
  adc_receiver_if.master bus
);

  localparam int                CNT_W   = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_SAT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic [CNT_W-1:0] lim);
    return (c >= lim) ? c : c + CNT_ONE;
  endfunction

  function automatic logic [WIDTH-1:0] put_bit(input logic [WIDTH-1:0] vec,
                                               input logic [CNT_W-1:0] cnt,
                                               input logic             b);
    logic [WIDTH-1:0] r;
    r = vec;
    for (int i = 0; i < WIDTH; i++)
      if (i == (WIDTH - 1) - int'(cnt)) r[i] = b;
    return r;
  endfunction

  // ---- stage p0: pin synchronisers (equal depth keeps the three pins aligned)
  logic bclk_p0, lrclk_p0, sd_p0;

  sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_bclk  (.clk(clk), .rst_n(rst_n), .d(bclk),  .q(bclk_p0));
  sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_lrclk (.clk(clk), .rst_n(rst_n), .d(lrclk), .q(lrclk_p0));
  sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_sd    (.clk(clk), .rst_n(rst_n), .d(sd),    .q(sd_p0));

  // ---- stage p1: edge detect; lrclk/sd delayed to line up with the bit event
  logic bclk_p1, bclk_p2, lrclk_p1, sd_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_p1  <= 1'b0;
      bclk_p2  <= 1'b0;
      lrclk_p1 <= 1'b0;
      sd_p1    <= 1'b0;
    end else begin
      bclk_p1  <= bclk_p0;
      bclk_p2  <= bclk_p1;
      lrclk_p1 <= lrclk_p0;
      sd_p1    <= sd_p0;
    end
  end

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic             lr_prev;
  logic             evt_p1;
  logic             hunt_lock, l_exit, r_exit, l_bit, r_bit, enter_left;

  assign evt_p1     = bclk_p1 & ~bclk_p2;
  assign hunt_lock  = evt_p1 & enable & (state == HUNT)  &  lrclk_p1 & ~lr_prev;
  assign l_exit     = evt_p1 & enable & (state == LEFT)  & ~lrclk_p1;
  assign l_bit      = evt_p1 & enable & (state == LEFT)  &  lrclk_p1;
  assign r_exit     = evt_p1 & enable & (state == RIGHT) &  lrclk_p1;
  assign r_bit      = evt_p1 & enable & (state == RIGHT) & ~lrclk_p1;
  assign enter_left = hunt_lock | r_exit;

  // ---- stage p2: channel shift registers and the completed pair awaiting commit
  logic [WIDTH-1:0] left_sh, right_sh, pend_left_p2, pend_right_p2;

  always_ff @(posedge clk) begin
    if (enter_left)
      left_sh <= {sd_p1, {(WIDTH-1){1'b0}}};
    else if (l_bit && bit_cnt < CNT_SAT)
      left_sh <= put_bit(left_sh, bit_cnt, sd_p1);

    if (l_exit)
      right_sh <= {sd_p1, {(WIDTH-1){1'b0}}};
    else if (r_bit && bit_cnt < CNT_SAT)
      right_sh <= put_bit(right_sh, bit_cnt, sd_p1);

    if (r_exit) begin
      pend_left_p2  <= left_sh;
      pend_right_p2 <= right_sh;
    end
  end

  logic             commit_p2;
  logic [WIDTH-1:0] left_q, right_q;
  logic             valid_q, overrun_q;
`ifdef ADC_RECEIVER_FRAME_CHECK_EN
  localparam logic [CNT_W-1:0] RAW_SAT = CNT_W'(2 * WIDTH);
  logic [CNT_W-1:0] raw_cnt;
  logic             err_left, pend_err_p2, ferr_q;
`endif

  // ---- stage p3: framing FSM, commit and output handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      bit_cnt   <= '0;
      lr_prev   <= 1'b1;  // no real previous event yet: never lock on the first high sample
      commit_p2 <= 1'b0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef ADC_RECEIVER_FRAME_CHECK_EN
      raw_cnt     <= '0;
      err_left    <= 1'b0;
      pend_err_p2 <= 1'b0;
      ferr_q      <= 1'b0;
`endif
    end else begin
      overrun_q <= 1'b0;
      commit_p2 <= r_exit;
`ifdef ADC_RECEIVER_FRAME_CHECK_EN
      ferr_q <= 1'b0;
      if (commit_p2) ferr_q <= pend_err_p2;
`endif

      // A commit may replace the presented pair only if it is being taken now.
      if (commit_p2) begin
        if (!valid_q || bus.ready) begin
          left_q  <= pend_left_p2;
          right_q <= pend_right_p2;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && bus.ready) begin
        valid_q <= 1'b0;
      end

      if (evt_p1) lr_prev <= lrclk_p1;

      if (!enable) begin
        state   <= HUNT;
        bit_cnt <= '0;
`ifdef ADC_RECEIVER_FRAME_CHECK_EN
        raw_cnt <= '0;
`endif
      end else if (enter_left || l_exit) begin
        state   <= l_exit ? RIGHT : LEFT;
        bit_cnt <= CNT_ONE;
`ifdef ADC_RECEIVER_FRAME_CHECK_EN
        raw_cnt <= CNT_ONE;
        if (l_exit) err_left <= (raw_cnt != CNT_SAT);
        if (r_exit) pend_err_p2 <= err_left | (raw_cnt != CNT_SAT);
`endif
      end else if (l_bit || r_bit) begin
        bit_cnt <= sat_inc(bit_cnt, CNT_SAT);
`ifdef ADC_RECEIVER_FRAME_CHECK_EN
        raw_cnt <= sat_inc(raw_cnt, RAW_SAT);
`endif
      end
    end
  end

  assign bus.left_data  = left_q;
  assign bus.right_data = right_q;
  assign bus.valid      = valid_q;
  assign bus.overrun    = overrun_q;
`ifdef ADC_RECEIVER_FRAME_CHECK_EN
  assign bus.frame_err  = ferr_q;
`else
  assign bus.frame_err  = 1'b0;
`endif

endmodule
